// File: rtl/prim_dispatch.sv
// Primitive dispatcher: hands one latched line/circle command to its engine, tracks completion,
// and aborts the engine if it makes no progress within TIMEOUT_CYCLES unstalled cycles.
module prim_dispatch #(
   parameter int unsigned TIMEOUT_CYCLES = 307200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_type,
   input  logic [37:0] cmd_positions,
   input  logic        mem_busy,
   input  logic        halt,
   input  logic        line_done,
   input  logic        circle_done,
   input  logic        err_clr,
   output logic [37:0] positions,
   output logic        line_start,
   output logic        circle_start,
   output logic        stop,
   output logic        engine_abort,
   output logic        prim_done,
   output logic        busy,
   output logic        timeout_err,
   output logic        err_badcmd,
   output logic [15:0] prim_count
);

   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, BUSY = 2'd2} state_e;

   localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic        sel_circle_q, sel_circle_d;
   logic [37:0] positions_q, positions_d;
   logic [19:0] wd_q, wd_d;
   logic [15:0] prim_count_q, prim_count_d;
   logic        line_start_q, line_start_d;
   logic        circle_start_q, circle_start_d;
   logic        stop_q, stop_d;
   logic        engine_abort_q, engine_abort_d;
   logic        prim_done_q, prim_done_d;
   logic        busy_q, busy_d;
   logic        timeout_err_q, timeout_err_d;
   logic        err_badcmd_q, err_badcmd_d;
   logic        accept;
   logic        done_sel;

   assign cmd_ready = (state_q == IDLE) && !halt;
   assign accept    = cmd_valid && cmd_ready;
   assign done_sel  = sel_circle_q ? circle_done : line_done;

   always_comb begin
      state_d        = state_q;
      sel_circle_d   = sel_circle_q;
      positions_d    = positions_q;
      wd_d           = wd_q;
      prim_count_d   = prim_count_q;
      line_start_d   = 1'b0;
      circle_start_d = 1'b0;
      engine_abort_d = 1'b0;
      prim_done_d    = 1'b0;
      err_badcmd_d   = 1'b0;
      timeout_err_d  = err_clr ? 1'b0 : timeout_err_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (cmd_type[1]) begin
                  err_badcmd_d = 1'b1;
               end else begin
                  positions_d    = cmd_positions;
                  sel_circle_d   = cmd_type[0];
                  line_start_d   = !cmd_type[0];
                  circle_start_d = cmd_type[0];
                  state_d        = START;
               end
            end
         end
         START: begin
            wd_d    = '0;
            state_d = BUSY;
         end
         BUSY: begin
            // A done seen on the limit cycle completes normally rather than aborting.
            if (done_sel) begin
               prim_done_d  = 1'b1;
               prim_count_d = prim_count_q + 16'd1;
               state_d      = IDLE;
            end else if (!stop_q) begin
               if (wd_q == WD_LAST) begin
                  engine_abort_d = 1'b1;
                  timeout_err_d  = 1'b1;
                  state_d        = IDLE;
               end else begin
                  wd_d = wd_q + 20'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      stop_d = (state_d == BUSY) && (mem_busy || halt);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         sel_circle_q   <= 1'b0;
         positions_q    <= '0;
         wd_q           <= '0;
         prim_count_q   <= '0;
         line_start_q   <= 1'b0;
         circle_start_q <= 1'b0;
         stop_q         <= 1'b0;
         engine_abort_q <= 1'b0;
         prim_done_q    <= 1'b0;
         busy_q         <= 1'b0;
         timeout_err_q  <= 1'b0;
         err_badcmd_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         sel_circle_q   <= sel_circle_d;
         positions_q    <= positions_d;
         wd_q           <= wd_d;
         prim_count_q   <= prim_count_d;
         line_start_q   <= line_start_d;
         circle_start_q <= circle_start_d;
         stop_q         <= stop_d;
         engine_abort_q <= engine_abort_d;
         prim_done_q    <= prim_done_d;
         busy_q         <= busy_d;
         timeout_err_q  <= timeout_err_d;
         err_badcmd_q   <= err_badcmd_d;
      end
   end

   assign positions    = positions_q;
   assign line_start   = line_start_q;
   assign circle_start = circle_start_q;
   assign stop         = stop_q;
   assign engine_abort = engine_abort_q;
   assign prim_done    = prim_done_q;
   assign busy         = busy_q;
   assign timeout_err  = timeout_err_q;
   assign err_badcmd   = err_badcmd_q;
   assign prim_count   = prim_count_q;

endmodule

// File: tb/tb_prim_dispatch.sv
// Directed bench for prim_dispatch: a default-timeout instance and a 16-cycle-timeout instance share inputs.
module tb_prim_dispatch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_type = 2'b00;
   logic [37:0] cmd_positions = '0;
   logic        mem_busy = 1'b0;
   logic        halt = 1'b0;
   logic        line_done = 1'b0;
   logic        circle_done = 1'b0;
   logic        err_clr = 1'b0;

   logic        cmd_ready, line_start, circle_start, stop, engine_abort;
   logic        prim_done, busy, timeout_err, err_badcmd;
   logic [37:0] positions;
   logic [15:0] prim_count;

   logic        t_cmd_ready, t_line_start, t_circle_start, t_stop, t_engine_abort;
   logic        t_prim_done, t_busy, t_timeout_err, t_err_badcmd;
   logic [37:0] t_positions;
   logic [15:0] t_prim_count;

   localparam logic [37:0] POS_C = {10'd320, 9'd240, 10'd470, 9'd0};
   localparam logic [37:0] POS_L = {10'd5, 9'd7, 10'd600, 9'd400};
   localparam logic [37:0] POS_R = {10'd1, 9'd2, 10'd3, 9'd4};

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   prim_dispatch u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_type(cmd_type), .cmd_positions(cmd_positions), .mem_busy(mem_busy),
      .halt(halt), .line_done(line_done), .circle_done(circle_done), .err_clr(err_clr),
      .positions(positions), .line_start(line_start), .circle_start(circle_start),
      .stop(stop), .engine_abort(engine_abort), .prim_done(prim_done), .busy(busy),
      .timeout_err(timeout_err), .err_badcmd(err_badcmd), .prim_count(prim_count)
   );

   prim_dispatch #(.TIMEOUT_CYCLES(16)) u_dut_to (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(t_cmd_ready),
      .cmd_type(cmd_type), .cmd_positions(cmd_positions), .mem_busy(mem_busy),
      .halt(halt), .line_done(line_done), .circle_done(circle_done), .err_clr(err_clr),
      .positions(t_positions), .line_start(t_line_start), .circle_start(t_circle_start),
      .stop(t_stop), .engine_abort(t_engine_abort), .prim_done(t_prim_done), .busy(t_busy),
      .timeout_err(t_timeout_err), .err_badcmd(t_err_badcmd), .prim_count(t_prim_count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cmd_valid = 1'b0; mem_busy = 1'b0; halt = 1'b0;
      line_done = 1'b0; circle_done = 1'b0; err_clr = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Presents a command for exactly one edge; returns #1 after that edge.
   task automatic send_cmd(input logic [1:0] ty, input logic [37:0] pos);
      cmd_valid = 1'b1;
      cmd_type = ty;
      cmd_positions = pos;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic complete_line(input string tag);
      send_cmd(2'b00, POS_L);
      line_done = 1'b1;
      tick();
      tick();
      line_done = 1'b0;
      chk(tag, prim_done, 1'b1);
   endtask

   initial begin
      int busy_n, done_n, cs_n, ls_n, abort_at, abort_n, tdone_n;

      // Reset state
      do_reset();
      chk("rst_busy", busy, 1'b0);
      chk("rst_positions", positions, 38'd0);
      chk("rst_prim_count", prim_count, 16'd0);
      chk("rst_stop", stop, 1'b0);
      chk("rst_timeout_err", timeout_err, 1'b0);
      chk("rst_cmd_ready", cmd_ready, 1'b1);

      // Circle dispatch, done presented 40 cycles after the accept edge
      send_cmd(2'b01, POS_C);
      chk("circ_start", circle_start, 1'b1);
      chk("circ_no_line_start", line_start, 1'b0);
      chk("circ_positions", positions, POS_C);
      chk("circ_not_ready", cmd_ready, 1'b0);
      busy_n = busy; cs_n = circle_start; done_n = 0;
      for (int i = 1; i <= 45; i++) begin
         circle_done = (i == 41);
         tick();
         busy_n += busy; cs_n += circle_start; done_n += prim_done;
      end
      circle_done = 1'b0;
      chk("circ_busy_cycles", busy_n, 41);
      chk("circ_start_count", cs_n, 1);
      chk("circ_done_count", done_n, 1);
      chk("circ_prim_count", prim_count, 16'd1);

      // Reserved type and halt in IDLE
      send_cmd(2'b11, POS_R);
      chk("bad_pulse", err_badcmd, 1'b1);
      chk("bad_no_start", {line_start, circle_start}, 2'b00);
      chk("bad_ready", cmd_ready, 1'b1);
      chk("bad_positions", positions, POS_C);
      tick();
      chk("bad_pulse_one_cycle", err_badcmd, 1'b0);
      halt = 1'b1;
      #1;
      chk("halt_ready", cmd_ready, 1'b0);
      send_cmd(2'b00, POS_L);
      chk("halt_no_accept", busy, 1'b0);
      halt = 1'b0;

      // Done in IDLE/START and from the wrong engine is ignored
      line_done = 1'b1;
      tick();
      line_done = 1'b0;
      chk("idle_done_ignored", prim_done, 1'b0);
      send_cmd(2'b00, POS_L);
      chk("line_start", line_start, 1'b1);
      circle_done = 1'b1;
      done_n = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         done_n += prim_done;
      end
      circle_done = 1'b0;
      chk("wrong_engine_ignored", {busy, 8'(done_n)}, {1'b1, 8'd0});
      line_done = 1'b1;
      tick();
      line_done = 1'b0;
      chk("line_done_pulse", prim_done, 1'b1);
      chk("line_prim_count", prim_count, 16'd2);
      tick();
      chk("line_done_one_cycle", prim_done, 1'b0);

      // Stall: mem_busy sampled high at edges 3..12 after accept
      do_reset();
      send_cmd(2'b01, POS_C);
      ls_n = line_start + t_line_start; abort_at = 0;
      for (int k = 1; k <= 30; k++) begin
         mem_busy = (k >= 3 && k <= 12);
         tick();
         if (k <= 16) chk($sformatf("stall_stop_k%0d", k), stop, (k >= 3 && k <= 12));
         ls_n += line_start + t_line_start;
         if (t_engine_abort && abort_at == 0) abort_at = k;
      end
      mem_busy = 1'b0;
      chk("stall_no_line_start", ls_n, 0);
      chk("stall_wd_frozen_abort_at", abort_at, 27);
      chk("stall_t_timeout_err", t_timeout_err, 1'b1);
      chk("stall_t_prim_count", t_prim_count, 16'd0);
      circle_done = 1'b1;
      tick();
      circle_done = 1'b0;
      chk("stall_finish", {prim_done, prim_count}, {1'b1, 16'd1});

      // Timeout with no done on the 16-cycle instance
      do_reset();
      send_cmd(2'b00, POS_L);
      abort_at = 0; abort_n = 0; tdone_n = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         abort_n += t_engine_abort;
         tdone_n += t_prim_done;
         if (t_engine_abort && abort_at == 0) abort_at = k;
      end
      chk("to_abort_at", abort_at, 17);
      chk("to_abort_count", abort_n, 1);
      chk("to_no_done", tdone_n, 0);
      chk("to_err_set", t_timeout_err, 1'b1);
      chk("to_prim_count", t_prim_count, 16'd0);
      chk("to_idle", t_busy, 1'b0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("to_err_clr", t_timeout_err, 1'b0);

      // Set and clear in the same cycle: set wins
      send_cmd(2'b00, POS_L);
      err_clr = 1'b1;
      for (int k = 1; k <= 17; k++) tick();
      chk("to_set_wins", {t_engine_abort, t_timeout_err}, 2'b11);
      tick();
      err_clr = 1'b0;
      chk("to_clr_after", t_timeout_err, 1'b0);

      // Done on the limit cycle wins over timeout
      send_cmd(2'b00, POS_L);
      for (int k = 1; k <= 17; k++) begin
         line_done = (k == 17);
         tick();
      end
      line_done = 1'b0;
      chk("prio_done", t_prim_done, 1'b1);
      chk("prio_no_abort", t_engine_abort, 1'b0);
      chk("prio_count", t_prim_count, 16'd1);

      // Asynchronous reset mid-BUSY, then a done arriving in IDLE
      do_reset();
      complete_line("rb_pre_done");
      send_cmd(2'b01, POS_C);
      mem_busy = 1'b1;
      repeat (5) tick();
      chk("rb_pre_stop", {busy, stop}, 2'b11);
      #2;
      rst = 1'b1;
      #1;
      chk("rb_async_outputs", {busy, stop, prim_done, engine_abort, line_start, circle_start, err_badcmd, timeout_err}, 8'd0);
      chk("rb_async_positions", positions, 38'd0);
      chk("rb_async_count", prim_count, 16'd0);
      mem_busy = 1'b0;
      tick();
      rst = 1'b0;
      line_done = 1'b1;
      done_n = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         done_n += prim_done;
      end
      line_done = 1'b0;
      chk("rb_no_done", done_n, 0);
      chk("rb_idle", {busy, stop, prim_count}, 18'd0);

      // Counter wrap: start two completions short of the 16-bit limit
      do_reset();
      @(negedge clk);
      force u_dut.prim_count_q = 16'hFFFE;
      #1;
      release u_dut.prim_count_q;
      tick();
      complete_line("wrap_done1");
      chk("wrap_ffff", prim_count, 16'hFFFF);
      complete_line("wrap_done2");
      chk("wrap_zero", prim_count, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/prim_dispatch.md
PRIM_DISPATCH -- requirements
Module: prim_dispatch

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 307200: max unstalled BUSY cycles before abort.
REQ-002 SHALL have ports, listed as name  direction  width  meaning.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  dispatcher can accept a command.
- cmd_type  in  2  00 line, 01 circle, 10/11 reserved.
- cmd_positions  in  38  {x[9:0], y[8:0], p2[9:0], p3[8:0]} primitive geometry.
- mem_busy  in  1  frame-buffer write path stalled.
- halt  in  1  software pause request.
- line_done  in  1  line engine finished (level or pulse).
- circle_done  in  1  circle engine finished (level or pulse).
- err_clr  in  1  clears timeout_err.
- positions  out  38  latched geometry driven to both engines.
- line_start  out  1  one-cycle primSelect to line engine.
- circle_start  out  1  one-cycle primSelect to circle engine.
- stop  out  1  stall to active engine.
- engine_abort  out  1  one-cycle abort pulse to both engines.
- prim_done  out  1  one-cycle completion pulse.
- busy  out  1  high in START or BUSY.
- timeout_err  out  1  sticky watchdog flag.
- err_badcmd  out  1  one-cycle reserved-type pulse.
- prim_count  out  16  completed-primitive counter.

Function
REQ-003 SHALL implement FSM states IDLE, START, BUSY; all outputs registered except cmd_ready.
REQ-004 SHALL drive cmd_ready = 1 only in IDLE and halt = 0.
REQ-005 SHALL accept a command on a rising edge with cmd_valid & cmd_ready; latch cmd_positions into positions and cmd_type into an internal type register.
REQ-006 SHALL, on accept of type 10/11, pulse err_badcmd for exactly one cycle, leave positions unchanged, and remain in IDLE.
REQ-007 SHALL, on accept of type 00/01, enter START; positions SHALL stay constant until the next accepted command.
REQ-008 SHALL, in START, assert exactly one of line_start/circle_start for exactly one cycle (the cycle after the accepting edge), clear the watchdog counter, then enter BUSY.
REQ-009 SHALL, in BUSY, drive stop = mem_busy | halt, registered (one-cycle latency).
REQ-010 SHALL increment a 20-bit watchdog counter each BUSY cycle with stop = 0; hold it while stop = 1.
REQ-011 SHALL, in BUSY, on done of the selected engine, pulse prim_done one cycle, increment prim_count (wrap 0xFFFF -> 0x0000), and return to IDLE.
REQ-012 SHALL ignore done from the non-selected engine and any done in IDLE or START.
REQ-013 SHALL, when the counter reaches TIMEOUT_CYCLES-1 with no valid done, pulse engine_abort one cycle, set timeout_err, leave prim_count unchanged, and return to IDLE.
REQ-014 SHALL give done priority over timeout in the same cycle.
REQ-015 SHALL clear timeout_err on err_clr; a set in the same cycle as err_clr SHALL win.
REQ-016 SHALL, with halt = 1 in IDLE, accept nothing; halt SHALL not affect START.

Reset
REQ-017 SHALL, on rst = 1 at any time, including mid-primitive, go to IDLE immediately.
REQ-018 SHALL, on reset, clear positions, the watchdog, prim_count, timeout_err and all pulse outputs, and drive stop = 0 and busy = 0; no abort pulse is issued.

Verification
REQ-019 Circle dispatch: accept type 01, positions {320,240,470,0}; circle_done 40 cycles later -> circle_start one cycle after accept, busy for 41 cycles, prim_done once, prim_count = 1.
REQ-020 Stall: mem_busy high for 10 cycles during BUSY -> stop high for the matching 10 cycles delayed by one cycle, watchdog frozen, line_start never asserted.
REQ-021 Timeout: TIMEOUT_CYCLES = 16, no done -> engine_abort after 16 unstalled BUSY cycles, timeout_err = 1, prim_count unchanged; err_clr -> timeout_err = 0.
REQ-022 Reserved type 11 -> err_badcmd one cycle, no start pulse, cmd_ready stays 1.
REQ-023 Reset mid-BUSY, plus a line_done arriving in IDLE -> all outputs zero, no prim_done.
REQ-024 Wrap: preload by 65535 completions, one more -> prim_count = 0.
